// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle controller and its datapath/memory.
// The controller side is the master: it issues mem_req_o and all datapath strobes.
interface multicycle_control_if #(
  parameter int INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] instr_i;
  logic                   eq_i;
  logic                   mem_ready_i;
  logic                   mem_req_o;
  logic                   PCWrite_o;
  logic                   AdrSrc_o;
  logic                   IRWrite_o;
  logic                   MemWrite_o;
  logic                   RegWrite_o;
  logic [1:0]             ResultSrc_o;
  logic [1:0]             ALUSrcA_o;
  logic [1:0]             ALUSrcB_o;
  logic [1:0]             ALUOp_o;
  logic                   illegal_o;

  modport master (
    input  instr_i, eq_i, mem_ready_i,
    output mem_req_o, PCWrite_o, AdrSrc_o, IRWrite_o, MemWrite_o, RegWrite_o,
           ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, illegal_o
  );

  modport slave (
    output instr_i, eq_i, mem_ready_i,
    input  mem_req_o, PCWrite_o, AdrSrc_o, IRWrite_o, MemWrite_o, RegWrite_o,
           ResultSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, illegal_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style main controller: Moore/Mealy FSM sequencing fetch,
// decode, memory, ALU, branch and JAL steps, with a sticky illegal-opcode trap.
module multicycle_control #(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [INSTR_WIDTH-1:0] instr_s;
  logic [6:0]             opcode_s;
  logic [2:0]             funct3_s;
  logic                   unused_instr_s;

  logic [3:0] state_r;
  logic [3:0] state_next_s;
  logic       run_r;
  logic       illegal_r;

  logic       mem_req_s;
  logic       pc_write_s;
  logic       adr_src_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;

  assign instr_s        = bus.instr_i;
  assign opcode_s       = instr_s[6:0];
  assign funct3_s       = instr_s[14:12];
  assign unused_instr_s = ^{instr_s[INSTR_WIDTH-1:15], instr_s[11:7]};

  // State, run qualifier and sticky illegal flag. run_r holds the FSM idle until
  // the first clock edge after reset so FETCH outputs appear only from that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_FETCH;
      run_r     <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (run_r) begin
        state_r   <= state_next_s;
        illegal_r <= illegal_r | (state_next_s == S_HALT);
      end else begin
        state_r   <= S_FETCH;
        illegal_r <= 1'b0;
      end
    end
  end

  // Next-state routing; unknown encodings fall into the HALT trap.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready_i) state_next_s = S_DECODE;
        else                 state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode_s)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_R:              state_next_s = S_EXEC_R;
          OP_I:              state_next_s = S_EXEC_I;
          OP_BRANCH:         state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_JAL;
          default:           state_next_s = S_HALT;
        endcase
      end
      S_MEMADR: begin
        if (opcode_s == OP_LOAD) state_next_s = S_MEMREAD;
        else                     state_next_s = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (bus.mem_ready_i) state_next_s = S_MEMWB;
        else                 state_next_s = S_MEMREAD;
      end
      S_MEMWB:    state_next_s = S_FETCH;
      S_MEMWRITE: begin
        if (bus.mem_ready_i) state_next_s = S_FETCH;
        else                 state_next_s = S_MEMWRITE;
      end
      S_EXEC_R:   state_next_s = S_ALUWB;
      S_EXEC_I:   state_next_s = S_ALUWB;
      S_ALUWB:    state_next_s = S_FETCH;
      S_BRANCH:   state_next_s = S_FETCH;
      S_JAL:      state_next_s = S_ALUWB;
      S_HALT:     state_next_s = S_HALT;
      default:    state_next_s = S_HALT;
    endcase
  end

  // Per-state control decode; everything stays low until run_r is set.
  always_comb begin
    mem_req_s    = 1'b0;
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    if (run_r) begin
      case (state_r)
        S_FETCH: begin
          mem_req_s    = 1'b1;
          ir_write_s   = bus.mem_ready_i;
          pc_write_s   = bus.mem_ready_i;
          alu_src_b_s  = 2'b10;
          result_src_s = 2'b10;
        end
        S_DECODE: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a_s = 2'b10;
          alu_src_b_s = 2'b01;
        end
        S_MEMREAD: begin
          mem_req_s = 1'b1;
          adr_src_s = 1'b1;
        end
        S_MEMWB: begin
          result_src_s = 2'b01;
          reg_write_s  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req_s   = 1'b1;
          adr_src_s   = 1'b1;
          mem_write_s = bus.mem_ready_i;
        end
        S_EXEC_R: begin
          alu_src_a_s = 2'b10;
          alu_op_s    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a_s = 2'b10;
          alu_src_b_s = 2'b01;
          alu_op_s    = 2'b10;
        end
        S_ALUWB: begin
          reg_write_s = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_s = 2'b10;
          alu_op_s    = 2'b01;
          // beq on equal, bne on not-equal; other funct3 values never redirect
          pc_write_s  = ((funct3_s == 3'b000) &&  bus.eq_i) ||
                        ((funct3_s == 3'b001) && !bus.eq_i);
        end
        S_JAL: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b10;
          pc_write_s  = 1'b1;
        end
        S_HALT: begin
          mem_req_s = 1'b0;
        end
        default: begin
          mem_req_s = 1'b0;
        end
      endcase
    end else begin
      mem_req_s = 1'b0;
    end
  end

  assign bus.mem_req_o   = mem_req_s;
  assign bus.PCWrite_o   = pc_write_s;
  assign bus.AdrSrc_o    = adr_src_s;
  assign bus.IRWrite_o   = ir_write_s;
  assign bus.MemWrite_o  = mem_write_s;
  assign bus.RegWrite_o  = reg_write_s;
  assign bus.ResultSrc_o = result_src_s;
  assign bus.ALUSrcA_o   = alu_src_a_s;
  assign bus.ALUSrcB_o   = alu_src_b_s;
  assign bus.ALUOp_o     = alu_op_s;
  assign bus.illegal_o   = illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus pushes hand-computed per-cycle
// control vectors into a scoreboard that a separate monitor pops and compares.
module tb_multicycle_control;

  // {illegal, mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  localparam logic [14:0] E_ZERO     = 15'd0;
  localparam logic [14:0] E_FETCH_R  = {1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00};
  localparam logic [14:0] E_FETCH_S  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00};
  localparam logic [14:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00};
  localparam logic [14:0] E_MEMADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00};
  localparam logic [14:0] E_MEMREAD  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00};
  localparam logic [14:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00};
  localparam logic [14:0] E_MEMWR_R  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00};
  localparam logic [14:0] E_MEMWR_S  = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00};
  localparam logic [14:0] E_EXEC_R   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10};
  localparam logic [14:0] E_EXEC_I   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10};
  localparam logic [14:0] E_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00};
  localparam logic [14:0] E_BR_T     = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01};
  localparam logic [14:0] E_BR_N     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01};
  localparam logic [14:0] E_JAL      = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00};
  localparam logic [14:0] E_HALT     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00};

  logic clk;
  logic rst;
  logic [14:0] act_s;
  int n_checks;
  int n_fail;
  event sample_ev;
  logic [14:0] sb_exp[$];
  string       sb_name[$];

  multicycle_control_if #(.INSTR_WIDTH(32)) bus();

  multicycle_control #(.INSTR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign act_s = {bus.illegal_o, bus.mem_req_o, bus.PCWrite_o, bus.AdrSrc_o, bus.IRWrite_o,
                  bus.MemWrite_o, bus.RegWrite_o, bus.ResultSrc_o, bus.ALUSrcA_o,
                  bus.ALUSrcB_o, bus.ALUOp_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares the oldest expectation on every falling edge or explicit sample.
  initial begin
    logic [14:0] exp_v;
    string nm;
    forever begin
      @(negedge clk or sample_ev);
      if (sb_exp.size() > 0) begin
        exp_v = sb_exp.pop_front();
        nm    = sb_name.pop_front();
        n_checks++;
        if (act_s !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b at %0t", nm, act_s, exp_v, $time);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic rdy, input logic eq,
                     input logic [14:0] exp_v, input string nm);
    @(posedge clk);
    #1;
    rst             = r;
    bus.mem_ready_i = rdy;
    bus.eq_i        = eq;
    sb_exp.push_back(exp_v);
    sb_name.push_back(nm);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
    @(negedge clk);
    #1;
    bus.instr_i = {17'h1abcd, f3, 5'b10101, op};
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.eq_i        = 1'b0;
    bus.instr_i     = 32'd0;

    // reset and release: outputs stay low until the first edge after release
    cyc(1'b1, 1'b1, 1'b0, E_ZERO, "reset_0");
    cyc(1'b1, 1'b1, 1'b0, E_ZERO, "reset_1");
    cyc(1'b0, 1'b1, 1'b0, E_ZERO, "post_release");

    // load, 5 cycles
    set_instr(7'b0000011, 3'b010);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "ld_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "ld_decode");
    cyc(1'b0, 1'b1, 1'b0, E_MEMADR,  "ld_memadr");
    cyc(1'b0, 1'b1, 1'b0, E_MEMREAD, "ld_memread");
    cyc(1'b0, 1'b1, 1'b0, E_MEMWB,   "ld_memwb");

    // R-type behind a 3-cycle fetch stall
    set_instr(7'b0110011, 3'b000);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, E_FETCH_S, "fetch_stall");
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "r_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "r_decode");
    cyc(1'b0, 1'b1, 1'b0, E_EXEC_R,  "r_exec");
    cyc(1'b0, 1'b1, 1'b0, E_ALUWB,   "r_aluwb");

    // store, 4 cycles
    set_instr(7'b0100011, 3'b010);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "st_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "st_decode");
    cyc(1'b0, 1'b1, 1'b0, E_MEMADR,  "st_memadr");
    cyc(1'b0, 1'b1, 1'b0, E_MEMWR_R, "st_memwrite");

    // I-type
    set_instr(7'b0010011, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "i_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "i_decode");
    cyc(1'b0, 1'b1, 1'b0, E_EXEC_I,  "i_exec");
    cyc(1'b0, 1'b1, 1'b0, E_ALUWB,   "i_aluwb");

    // JAL
    set_instr(7'b1101111, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "jal_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "jal_decode");
    cyc(1'b0, 1'b1, 1'b0, E_JAL,     "jal_jal");
    cyc(1'b0, 1'b1, 1'b0, E_ALUWB,   "jal_aluwb");

    // branches: bne/eq0 taken, bne/eq1 not, beq/eq1 taken, beq/eq0 not, funct3=100 never
    set_instr(7'b1100011, 3'b001);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "bne0_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "bne0_decode");
    cyc(1'b0, 1'b1, 1'b0, E_BR_T,    "bne_eq0_taken");
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "bne1_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "bne1_decode");
    cyc(1'b0, 1'b1, 1'b1, E_BR_N,    "bne_eq1_not_taken");
    set_instr(7'b1100011, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "beq1_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "beq1_decode");
    cyc(1'b0, 1'b1, 1'b1, E_BR_T,    "beq_eq1_taken");
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "beq0_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "beq0_decode");
    cyc(1'b0, 1'b1, 1'b0, E_BR_N,    "beq_eq0_not_taken");
    set_instr(7'b1100011, 3'b100);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "f3x_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "f3x_decode");
    cyc(1'b0, 1'b1, 1'b1, E_BR_N,    "f3_100_no_write");

    // load with a 2-cycle memory stall
    set_instr(7'b0000011, 3'b010);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "lds_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "lds_decode");
    cyc(1'b0, 1'b1, 1'b0, E_MEMADR,  "lds_memadr");
    cyc(1'b0, 1'b0, 1'b0, E_MEMREAD, "lds_memread_wait0");
    cyc(1'b0, 1'b0, 1'b0, E_MEMREAD, "lds_memread_wait1");
    cyc(1'b0, 1'b1, 1'b0, E_MEMREAD, "lds_memread_done");
    cyc(1'b0, 1'b1, 1'b0, E_MEMWB,   "lds_memwb");

    // store stalled in MEMWRITE, aborted by an asynchronous reset between edges
    set_instr(7'b0100011, 3'b010);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "sta_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "sta_decode");
    cyc(1'b0, 1'b0, 1'b0, E_MEMADR,  "sta_memadr");
    cyc(1'b0, 1'b0, 1'b0, E_MEMWR_S, "sta_memwrite_wait0");
    cyc(1'b0, 1'b0, 1'b0, E_MEMWR_S, "sta_memwrite_wait1");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb_exp.push_back(E_ZERO);
    sb_name.push_back("async_rst_outputs");
    -> sample_ev;
    cyc(1'b1, 1'b1, 1'b0, E_ZERO,    "rst_hold");
    cyc(1'b0, 1'b1, 1'b0, E_ZERO,    "post_release_abort");
    set_instr(7'b0010011, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "fetch_after_abort");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "decode_after_abort");
    cyc(1'b0, 1'b1, 1'b0, E_EXEC_I,  "exec_after_abort");
    cyc(1'b0, 1'b1, 1'b0, E_ALUWB,   "aluwb_after_abort");

    // illegal opcode: trap in HALT, no requests, cleared only by reset
    set_instr(7'b1111111, 3'b000);
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "ill_fetch");
    cyc(1'b0, 1'b1, 1'b0, E_DECODE,  "ill_decode");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, E_HALT, "ill_halt");
    cyc(1'b1, 1'b1, 1'b0, E_ZERO,    "rst_clears_illegal");
    cyc(1'b0, 1'b1, 1'b0, E_ZERO,    "post_release_ill");
    cyc(1'b0, 1'b1, 1'b0, E_FETCH_R, "fetch_after_halt");

    @(negedge clk);
    #1;
    if (sb_exp.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
